// File: rtl/lamp_sequence_monitor.sv
// Receive-side checker for the one-hot traffic-lamp bus. It tracks the lamp phase, checks the
// encoding, the GREEN->YELLOW->RED order and per-colour dwell, counts cycles and raises sticky error flags.
module lamp_sequence_monitor #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 1,
  parameter int DW_W      = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       lamp,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             in_sync,
  output logic [CNT_W-1:0] cycle_count,
  output logic             err_pulse,
  output logic [2:0]       err_flags
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    RED    = 2'd3
  } phase_t;

  localparam logic [DW_W-1:0] DW_SAT = '1;
  localparam logic [DW_W-1:0] DW_ONE = DW_W'(1);
  localparam logic [DW_W-1:0] MIN_D  = DW_W'(MIN_DWELL);
  localparam logic [DW_W-1:0] MAX_D  = DW_W'(MAX_DWELL);

  phase_t           state_q, state_d;
  phase_t           lamp_ph, succ_ph;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       flags_q, flags_d;
  logic             pulse_q, pulse_d;
  logic [2:0]       errs;

  // Invalid codes (000, multi-hot) decode to IDLE so one compare covers "not a colour".
  always_comb begin
    lamp_ph = IDLE;
    case (lamp)
      3'b010:  lamp_ph = GREEN;
      3'b001:  lamp_ph = YELLOW;
      3'b100:  lamp_ph = RED;
      default: lamp_ph = IDLE;
    endcase
  end

  always_comb begin
    succ_ph = IDLE;
    case (state_q)
      GREEN:   succ_ph = YELLOW;
      YELLOW:  succ_ph = RED;
      RED:     succ_ph = GREEN;
      default: succ_ph = IDLE;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    count_d = count_q;
    errs    = 3'b000;

    if (state_q == IDLE) begin
      if (lamp_ph != IDLE) begin
        state_d = lamp_ph;
        dwell_d = DW_ONE;
      end
    end else if (lamp_ph == IDLE) begin
      errs[0] = 1'b1;
      state_d = IDLE;
      dwell_d = '0;
    end else if (lamp_ph == state_q) begin
      if (dwell_q != DW_SAT) dwell_d = dwell_q + DW_ONE;
      // Fires only on the step from MAX to MAX+1, so a long stay reports once.
      if (dwell_q == MAX_D) errs[2] = 1'b1;
    end else if (lamp_ph == succ_ph) begin
      if (dwell_q < MIN_D) errs[2] = 1'b1;
      if (state_q == RED) count_d = count_q + CNT_W'(1);
      state_d = lamp_ph;
      dwell_d = DW_ONE;
    end else begin
      errs[1] = 1'b1;
      state_d = lamp_ph;
      dwell_d = DW_ONE;
    end

    // A fresh error on the clearing edge survives the clear.
    flags_d = (clr_err ? 3'b000 : flags_q) | errs;
    pulse_d = |errs;
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dwell_q <= '0;
      count_q <= '0;
      flags_q <= 3'b000;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      count_q <= count_d;
      flags_q <= flags_d;
      pulse_q <= pulse_d;
    end
  end

  assign phase       = state_q;
  assign in_sync     = (state_q != IDLE);
  assign cycle_count = count_q;
  assign err_pulse   = pulse_q;
  assign err_flags   = flags_q;

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Self-checking bench for lamp_sequence_monitor: three instances (defaults, MIN=2/MAX=3, CNT_W=4)
// each compared every cycle against a colour-index model, plus directed literal expectations.
module tb_lamp_sequence_monitor;

  localparam logic [2:0] R = 3'b100, G = 3'b010, Y = 3'b001, Z = 3'b000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  lamp [3];
  logic        clr [3];
  logic [1:0]  phase_o [3];
  logic        sync_o [3];
  logic        pulse_o [3];
  logic [2:0]  flags_o [3];
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  lamp_sequence_monitor dut_a (
    .clock(clock), .reset_n(reset_n), .lamp(lamp[0]), .clr_err(clr[0]),
    .phase(phase_o[0]), .in_sync(sync_o[0]), .cycle_count(cnt_a),
    .err_pulse(pulse_o[0]), .err_flags(flags_o[0])
  );

  lamp_sequence_monitor #(.MIN_DWELL(2), .MAX_DWELL(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .lamp(lamp[1]), .clr_err(clr[1]),
    .phase(phase_o[1]), .in_sync(sync_o[1]), .cycle_count(cnt_b),
    .err_pulse(pulse_o[1]), .err_flags(flags_o[1])
  );

  lamp_sequence_monitor #(.CNT_W(4)) dut_c (
    .clock(clock), .reset_n(reset_n), .lamp(lamp[2]), .clr_err(clr[2]),
    .phase(phase_o[2]), .in_sync(sync_o[2]), .cycle_count(cnt_c),
    .err_pulse(pulse_o[2]), .err_flags(flags_o[2])
  );

  // Model: phase is a colour index 1..3 (0 = unsynced); the successor of p is p%3+1.
  typedef struct {
    int         phase;
    int         dwell;
    int         count;
    logic [2:0] flags;
    logic       pulse;
  } mstate_t;

  mstate_t m [3];
  int      p_min [3] = '{1, 2, 1};
  int      p_max [3] = '{1, 3, 1};
  int      p_cw  [3] = '{16, 16, 4};

  function automatic mstate_t m_reset();
    mstate_t s;
    s.phase = 0; s.dwell = 0; s.count = 0; s.flags = 3'b000; s.pulse = 1'b0;
    return s;
  endfunction

  function automatic mstate_t m_step(mstate_t s, logic [2:0] l, logic c_clr, int mn, int mx, int cw);
    mstate_t    n;
    logic [2:0] e;
    int         c;
    n = s;
    e = 3'b000;
    case (l)
      3'b010:  c = 1;
      3'b001:  c = 2;
      3'b100:  c = 3;
      default: c = 0;
    endcase
    if (s.phase == 0) begin
      if (c != 0) begin n.phase = c; n.dwell = 1; end
    end else if (c == 0) begin
      e[0] = 1'b1; n.phase = 0; n.dwell = 0;
    end else if (c == s.phase) begin
      if (s.dwell < 255) n.dwell = s.dwell + 1;
      if (n.dwell == mx + 1 && n.dwell != s.dwell) e[2] = 1'b1;
    end else if (c == s.phase % 3 + 1) begin
      if (s.dwell < mn) e[2] = 1'b1;
      if (s.phase == 3) n.count = (s.count + 1) % (1 << cw);
      n.phase = c; n.dwell = 1;
    end else begin
      e[1] = 1'b1; n.phase = c; n.dwell = 1;
    end
    n.flags = (c_clr ? 3'b000 : s.flags) | e;
    n.pulse = (e != 3'b000);
    return n;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) m[i] = m_reset();
    end else begin
      for (int i = 0; i < 3; i++) m[i] = m_step(m[i], lamp[i], clr[i], p_min[i], p_max[i], p_cw[i]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] pack(logic [1:0] ph, logic s, logic p, logic [2:0] f, logic [15:0] c);
    return {9'b0, ph, s, p, f, c};
  endfunction

  function automatic logic [15:0] dut_count(int i);
    if (i == 0) return cnt_a;
    if (i == 1) return cnt_b;
    return {12'b0, cnt_c};
  endfunction

  // Packed layout: {phase, in_sync, err_pulse, err_flags, cycle_count}.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model_cmp_inst%0d", i),
            pack(phase_o[i], sync_o[i], pulse_o[i], flags_o[i], dut_count(i)),
            pack(2'(m[i].phase), m[i].phase != 0, m[i].pulse, m[i].flags, 16'(m[i].count)));
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic drive(input int i, input logic [2:0] l);
    lamp[i] = l;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin lamp[i] = Z; clr[i] = 1'b0; end
    tick();
    tick();
    check("reset_phase", 32'(phase_o[0]), 32'd0);
    check("reset_flags", 32'(flags_o[0]), 32'd0);
    reset_n = 1'b1;

    // Startup zeros, then one legal lap.
    for (int k = 0; k < 5; k++) begin
      drive(0, Z);
      check("idle_on_zero", 32'(phase_o[0]), 32'd0);
    end
    drive(0, G); check("lap_green", 32'(phase_o[0]), 32'd1);
    drive(0, Y); check("lap_yellow", 32'(phase_o[0]), 32'd2);
    drive(0, R); check("lap_red", 32'(phase_o[0]), 32'd3);
    drive(0, G); check("lap_back_green", 32'(phase_o[0]), 32'd1);
    check("lap_count", 32'(cnt_a), 32'd1);
    check("lap_no_errors", 32'(flags_o[0]), 32'd0);

    // GREEN -> RED is out of order.
    drive(0, R);
    check("seq_flags", 32'(flags_o[0]), 32'b010);
    check("seq_pulse", 32'(pulse_o[0]), 32'd1);
    check("seq_phase", 32'(phase_o[0]), 32'd3);
    drive(0, G);
    check("seq_pulse_drop", 32'(pulse_o[0]), 32'd0);
    check("seq_then_count", 32'(cnt_a), 32'd2);

    // Multi-hot from YELLOW, then resync on YELLOW.
    drive(0, Y);
    drive(0, 3'b110);
    check("enc_flags", 32'(flags_o[0]), 32'b011);
    check("enc_phase", 32'(phase_o[0]), 32'd0);
    drive(0, Y);
    check("resync_phase", 32'(phase_o[0]), 32'd2);
    check("resync_no_pulse", 32'(pulse_o[0]), 32'd0);

    // clr_err alone while unsynced.
    drive(0, Z);
    clr[0] = 1'b1;
    drive(0, Z);
    clr[0] = 1'b0;
    check("clr_flags", 32'(flags_o[0]), 32'd0);
    check("clr_phase_kept", 32'(phase_o[0]), 32'd0);

    // Sequence error recorded, then dwell error on the clearing edge.
    drive(0, G);
    drive(0, R);
    check("pre_clr_flags", 32'(flags_o[0]), 32'b010);
    clr[0] = 1'b1;
    drive(0, R);
    clr[0] = 1'b0;
    check("clr_vs_new_err", 32'(flags_o[0]), 32'b100);
    check("clr_vs_new_pulse", 32'(pulse_o[0]), 32'd1);
    drive(0, G);
    check("post_clr_count", 32'(cnt_a), 32'd3);

    // Reset asserted mid-phase.
    drive(0, Y);
    reset_n = 1'b0;
    #1;
    check("midreset_phase", 32'(phase_o[0]), 32'd0);
    check("midreset_count", 32'(cnt_a), 32'd0);
    check("midreset_flags", 32'(flags_o[0]), 32'd0);
    tick();
    reset_n = 1'b1;
    drive(0, Y);
    check("post_reset_resync", 32'(phase_o[0]), 32'd2);
    check("post_reset_no_err", 32'(flags_o[0]), 32'd0);
    drive(0, R);
    drive(0, Z);

    // MIN=2, MAX=3 dwell checks.
    drive(1, G);
    drive(1, Y);
    check("short_dwell_flags", 32'(flags_o[1]), 32'b100);
    check("short_dwell_pulse", 32'(pulse_o[1]), 32'd1);
    drive(1, Y); check("dwell2_quiet", 32'(pulse_o[1]), 32'd0);
    drive(1, Y); check("dwell3_quiet", 32'(pulse_o[1]), 32'd0);
    drive(1, Y); check("dwell4_pulse", 32'(pulse_o[1]), 32'd1);
    drive(1, Y); check("dwell5_no_repeat", 32'(pulse_o[1]), 32'd0);
    drive(1, R);
    check("long_then_legal", 32'(pulse_o[1]), 32'd0);
    check("long_then_phase", 32'(phase_o[1]), 32'd3);
    drive(1, G);
    drive(1, Z);

    // Cycle-counter wrap on the 4-bit instance.
    drive(2, G);
    for (int k = 1; k <= 16; k++) begin
      drive(2, Y);
      drive(2, R);
      drive(2, G);
      if (k == 15) check("wrap_count_15", 32'(cnt_c), 32'd15);
      if (k == 16) check("wrap_count_0", 32'(cnt_c), 32'd0);
    end
    check("wrap_no_errors", 32'(flags_o[2]), 32'd0);
    drive(2, Z);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
